stopwatch_datapath: RTL and testbench

Counter/display datapath that answers the stopwatch/timer controller's command interface. Holds a 0–9999 hundredths-of-a-second count (display format SS.hh), loads/clears it, and counts up or down on a 100 Hz tick under controller command. Reports the terminal condition back to the controller and drives the 4-digit multiplexed seven-segment display.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/stopwatch_datapath_if.sv | 25 ++
 rtl/bin_to_bcd.sv | 59 +++++
 rtl/stopwatch_datapath.sv | 121 ++++++++++++
 tb/tb_stopwatch_datapath.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch counter/display datapath:
// controller command codes, count limits and the BCD to seven-segment table.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    CTR_LOAD  = 3'd0,
    CTR_UP    = 3'd1,
    CTR_DOWN  = 3'd2,
    CTR_CLEAR = 3'd3
  } ctr_sel_e;

  localparam int COUNT_W = 14;
  localparam int INIT_W  = 17;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 14'd9999;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; codes 10-15 never come out of the converter and show blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    return SEG_TABLE[bcd];
  endfunction

endpackage

// File: rtl/stopwatch_datapath_if.sv
// Command/status bus between the stopwatch controller (master) and the
// counter/display datapath (slave).
interface stopwatch_datapath_if;
  import stopwatch_pkg::*;

  logic              init_ld_en;
  logic              count_en;
  logic [2:0]        ctrSelect;
  logic [INIT_W-1:0] InitVal;
  logic              tcSelect;
  logic              anReset;
  logic              tcLimitReached;
  logic [INIT_W-1:0] synchInit;

  modport master (
    output init_ld_en, count_en, ctrSelect, InitVal, tcSelect, anReset,
    input  tcLimitReached, synchInit
  );

  modport slave (
    input  init_ld_en, count_en, ctrSelect, InitVal, tcSelect, anReset,
    output tcLimitReached, synchInit
  );

endinterface

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble: converts a 14-bit binary value to four BCD digits,
// one shift per cycle, done pulses 14 cycles after an accepted start.
module bin_to_bcd
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [3:0][3:0]    digits
);

  logic [COUNT_W-1:0] shreg;
  logic [3:0][3:0]    acc;
  logic [3:0][3:0]    acc_adj;
  logic [3:0]         step_cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] >= 4'd5) acc_adj[i] = acc[i] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        busy     <= 1'b1;
        step_cnt <= '0;
      end else if (busy) begin
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt == 4'(COUNT_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Shift datapath carries no reset: it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (!busy && start) begin
      shreg <= bin;
      acc   <= '0;
    end else if (busy) begin
      {acc, shreg} <= {acc_adj, shreg} << 1;
    end
  end

  assign digits = acc;

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch counter (0-9999 hundredths) with load/clear/up/down control and a
// 4-digit multiplexed display. Option: STOPWATCH_LEADING_ZERO_BLANK_EN blanks a zero tens-of-seconds digit.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_DIV    = 1_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                clk,
  input  logic                reset,
  stopwatch_datapath_if.slave bus,
  output logic [3:0]          an,
  output logic [6:0]          sseg
);

  localparam int PS_W = $clog2(TICK_DIV + 1);
  localparam int RF_W = $clog2(REFRESH_DIV + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 16 || TICK_DIV < 1 || CLK_HZ < 1) begin : g_bad_cfg
    $error("stopwatch_datapath: invalid divider configuration");
  end

  ctr_sel_e           sel;
  logic               load, run, tick;
  logic [COUNT_W-1:0] count;
  logic [PS_W-1:0]    prescaler;
  logic [RF_W-1:0]    refresh;
  logic [1:0]         digit_idx;
  logic               slot_end, conv_start, conv_busy, conv_done;
  logic [3:0][3:0]    conv_digits, disp_digits;
  logic [3:0]         cur_digit;
  logic [6:0]         cur_seg;

  function automatic logic [COUNT_W-1:0] clamp_init(input logic [INIT_W-1:0] v);
    return (v > INIT_W'(COUNT_MAX)) ? COUNT_MAX : v[COUNT_W-1:0];
  endfunction

  function automatic logic [COUNT_W-1:0] step_count(input logic [COUNT_W-1:0] c,
                                                    input logic up);
    if (up) return (c == COUNT_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  assign sel  = ctr_sel_e'(bus.ctrSelect);
  assign load = bus.init_ld_en && (sel == CTR_LOAD || sel == CTR_CLEAR);
  assign run  = bus.count_en && (sel == CTR_UP || sel == CTR_DOWN);
  assign tick = run && (prescaler == PS_LAST);

  // Count, prescaler and controller status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count              <= '0;
      prescaler          <= '0;
      bus.synchInit      <= '0;
      bus.tcLimitReached <= 1'b0;
    end else begin
      bus.tcLimitReached <= bus.tcSelect ? (count == '0) : (count == COUNT_MAX);
      if (load) begin
        count         <= (sel == CTR_LOAD) ? clamp_init(bus.InitVal) : '0;
        bus.synchInit <= bus.InitVal;
        prescaler     <= '0;
      end else if (run) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) count <= step_count(count, sel == CTR_UP);
      end
    end
  end

  // Refresh scan; a new snapshot is converted each time the scan returns to digit 0
  assign slot_end   = (refresh == RF_LAST);
  assign conv_start = slot_end && (digit_idx == 2'd3) && !conv_busy;

  bin_to_bcd u_bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .bin    (count),
    .busy   (conv_busy),
    .done   (conv_done),
    .digits (conv_digits)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh     <= '0;
      digit_idx   <= '0;
      disp_digits <= '0;
    end else begin
      refresh <= slot_end ? '0 : refresh + 1'b1;
      if (slot_end) digit_idx <= digit_idx + 1'b1;
      if (conv_done) disp_digits <= conv_digits;
    end
  end

  assign cur_digit = disp_digits[digit_idx];

  always_comb begin
    cur_seg = bcd_to_seg(cur_digit);
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    if (digit_idx == 2'd3 && cur_digit == 4'd0) cur_seg = SEG_BLANK;
`endif
  end

  // Registered display drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= 4'b1111;
      sseg <= SEG_BLANK;
    end else if (bus.anReset) begin
      an   <= 4'b1111;
      sseg <= SEG_BLANK;
    end else begin
      an   <= ~(4'b0001 << digit_idx);
      sseg <= cur_seg;
    end
  end

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Randomized, model-checked bench for stopwatch_datapath with short dividers.
module tb_stopwatch_datapath;

  localparam int TICK_DIV    = 4;
  localparam int REFRESH_DIV = 20;
  localparam int SETTLE      = 4 * REFRESH_DIV + 16;
  localparam int SCAN        = 4 * REFRESH_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] sseg;

  stopwatch_datapath_if bus();

  stopwatch_datapath #(
    .CLK_HZ      (100_000_000),
    .TICK_DIV    (TICK_DIV),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .an    (an),
    .sseg  (sseg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int   m_count, m_sync, m_phase;
  logic m_tc;

  logic [6:0] seen [4];
  logic [3:0] seen_mask;

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] expect_seg(input int v, input int pos);
    int d;
    d = v;
    for (int k = 0; k < pos; k++) d = d / 10;
    d = d % 10;
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    if (pos == 3 && d == 0) return 7'b1111111;
`endif
    return seg_ref(d);
  endfunction

  task automatic drive(input logic ld, input logic en, input logic [2:0] sel,
                       input int init, input logic tcs);
    bus.init_ld_en = ld;
    bus.count_en   = en;
    bus.ctrSelect  = sel;
    bus.InitVal    = 17'(init);
    bus.tcSelect   = tcs;
  endtask

  // Advance one clock; the reference model consumes the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_count = 0; m_sync = 0; m_tc = 1'b0; m_phase = 0;
    end else begin
      m_tc = bus.tcSelect ? (m_count == 0) : (m_count == 9999);
      if (bus.init_ld_en && (bus.ctrSelect == 3'd0 || bus.ctrSelect == 3'd3)) begin
        if (bus.ctrSelect == 3'd0) m_count = (int'(bus.InitVal) > 9999) ? 9999 : int'(bus.InitVal);
        else m_count = 0;
        m_sync  = int'(bus.InitVal);
        m_phase = 0;
      end else if (bus.count_en && (bus.ctrSelect == 3'd1 || bus.ctrSelect == 3'd2)) begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          if (bus.ctrSelect == 3'd1) m_count = (m_count < 9999) ? m_count + 1 : 9999;
          else m_count = (m_count > 0) ? m_count - 1 : 0;
        end
      end
    end
    #1;
  endtask

  task automatic scan_display();
    seen_mask = '0;
    for (int c = 0; c < SCAN; c++) begin
      step();
      case (an)
        4'b1110: begin seen[0] = sseg; seen_mask[0] = 1'b1; end
        4'b1101: begin seen[1] = sseg; seen_mask[1] = 1'b1; end
        4'b1011: begin seen[2] = sseg; seen_mask[2] = 1'b1; end
        4'b0111: begin seen[3] = sseg; seen_mask[3] = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.anReset = 1'b0;
    drive(1'b0, 1'b0, 3'd4, 0, 1'b0);
    #1 reset = 1'b1;
    #2;
    total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=1111", an); end
    total++; if (sseg !== 7'b1111111) begin bad++; $display("FAIL reset_sseg got=%b want=1111111", sseg); end
    total++; if (bus.tcLimitReached !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", bus.tcLimitReached); end
    total++; if (bus.synchInit !== 17'd0) begin bad++; $display("FAIL reset_synch got=%0d want=0", bus.synchInit); end
    total++; if (int'(dut.count) !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", dut.count); end
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_load();
    drive(1'b1, 1'b0, 3'd0, 1234, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd4, 0, 1'b0);
    total++; if (int'(dut.count) !== 1234) begin bad++; $display("FAIL load_count got=%0d want=1234", dut.count); end
    total++; if (bus.synchInit !== 17'd1234) begin bad++; $display("FAIL load_synch got=%0d want=1234", bus.synchInit); end
    step();
    total++; if (bus.tcLimitReached !== m_tc) begin bad++; $display("FAIL load_tc got=%b want=%b", bus.tcLimitReached, m_tc); end
    repeat (SETTLE) step();
    scan_display();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (!seen_mask[i] || seen[i] !== expect_seg(1234, i))
        begin bad++; $display("FAIL load_digit%0d got=%b want=%b", i, seen[i], expect_seg(1234, i)); end
    end
  endtask

  task automatic test_clamp();
    drive(1'b1, 1'b0, 3'd0, 12000, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd4, 0, 1'b0);
    total++; if (bus.synchInit !== 17'd12000) begin bad++; $display("FAIL clamp_synch got=%0d want=12000", bus.synchInit); end
    total++; if (int'(dut.count) !== 9999) begin bad++; $display("FAIL clamp_count got=%0d want=9999", dut.count); end
    total++; if (bus.tcLimitReached !== 1'b0) begin bad++; $display("FAIL clamp_tc_early got=%b want=0", bus.tcLimitReached); end
    step();
    total++; if (bus.tcLimitReached !== 1'b1) begin bad++; $display("FAIL clamp_tc got=%b want=1", bus.tcLimitReached); end
  endtask

  task automatic test_count_up();
    drive(1'b1, 1'b0, 3'd3, 0, 1'b0);
    step();
    drive(1'b0, 1'b1, 3'd1, 0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step();
      total++; if (int'(dut.count) !== m_count) begin bad++; $display("FAIL up_track c=%0d got=%0d want=%0d", c, dut.count, m_count); end
    end
    total++; if (int'(dut.count) !== 10) begin bad++; $display("FAIL up_count got=%0d want=10", dut.count); end
    drive(1'b0, 1'b0, 3'd1, 0, 1'b0);
    repeat (40) step();
    total++; if (int'(dut.count) !== 10) begin bad++; $display("FAIL pause_count got=%0d want=10", dut.count); end
    drive(1'b0, 1'b1, 3'd1, 0, 1'b0);
    repeat (2) step();
    drive(1'b0, 1'b0, 3'd1, 0, 1'b0);
    repeat (2) step();
    drive(1'b0, 1'b1, 3'd1, 0, 1'b0);
    step();
    total++; if (int'(dut.count) !== 10) begin bad++; $display("FAIL resume_early got=%0d want=10", dut.count); end
    step();
    total++; if (int'(dut.count) !== 11) begin bad++; $display("FAIL resume_tick got=%0d want=11", dut.count); end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 3'd0, 3, 1'b1);
    step();
    drive(1'b0, 1'b1, 3'd2, 0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      step();
      total++; if (int'(dut.count) !== m_count) begin bad++; $display("FAIL down_track c=%0d got=%0d want=%0d", c, dut.count, m_count); end
      total++; if (bus.tcLimitReached !== m_tc) begin bad++; $display("FAIL down_tc c=%0d got=%b want=%b", c, bus.tcLimitReached, m_tc); end
      if (c == 12) begin
        total++; if (int'(dut.count) !== 0 || bus.tcLimitReached !== 1'b0)
          begin bad++; $display("FAIL down_zero got=%0d/%b want=0/0", dut.count, bus.tcLimitReached); end
      end
      if (c == 13) begin
        total++; if (bus.tcLimitReached !== 1'b1) begin bad++; $display("FAIL down_tc_rise got=%b want=1", bus.tcLimitReached); end
      end
    end
    total++; if (int'(dut.count) !== 0) begin bad++; $display("FAIL down_hold got=%0d want=0", dut.count); end
  endtask

  task automatic test_an_reset();
    drive(1'b1, 1'b0, 3'd0, 500, 1'b0);
    step();
    drive(1'b0, 1'b1, 3'd1, 0, 1'b0);
    bus.anReset = 1'b1;
    repeat (2) step();
    for (int c = 0; c < 30; c++) begin
      step();
      total++; if (an !== 4'b1111 || sseg !== 7'b1111111)
        begin bad++; $display("FAIL anreset_blank c=%0d got=%b/%b want=1111/1111111", c, an, sseg); end
      total++; if (int'(dut.count) !== m_count) begin bad++; $display("FAIL anreset_count got=%0d want=%0d", dut.count, m_count); end
    end
    total++; if (int'(dut.count) !== 508) begin bad++; $display("FAIL anreset_advance got=%0d want=508", dut.count); end
    bus.anReset = 1'b0;
    drive(1'b0, 1'b0, 3'd4, 0, 1'b0);
    repeat (SETTLE) step();
    scan_display();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (!seen_mask[i] || seen[i] !== expect_seg(m_count, i))
        begin bad++; $display("FAIL anreset_digit%0d got=%b want=%b", i, seen[i], expect_seg(m_count, i)); end
    end
  endtask

  task automatic test_random();
    int r, init;
    logic [2:0] sel;
    for (int c = 0; c < 400; c++) begin
      r    = int'($urandom_range(0, 15));
      sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) sel = 3'($urandom_range(1, 2));
      case ($urandom_range(0, 3))
        0: init = int'($urandom_range(0, 5));
        1: init = int'($urandom_range(9995, 9999));
        2: init = int'($urandom_range(10000, 131071));
        default: init = int'($urandom_range(0, 9999));
      endcase
      drive(r == 0, r > 3, sel, init, 1'($urandom_range(0, 1)));
      step();
      total++; if (int'(dut.count) !== m_count) begin bad++; $display("FAIL rand_count c=%0d got=%0d want=%0d", c, dut.count, m_count); end
      total++; if (int'(bus.synchInit) !== m_sync) begin bad++; $display("FAIL rand_synch c=%0d got=%0d want=%0d", c, bus.synchInit, m_sync); end
      total++; if (bus.tcLimitReached !== m_tc) begin bad++; $display("FAIL rand_tc c=%0d got=%b want=%b", c, bus.tcLimitReached, m_tc); end
    end
    drive(1'b0, 1'b0, 3'd5, 0, 1'b0);
    repeat (SETTLE) step();
    scan_display();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (!seen_mask[i] || seen[i] !== expect_seg(m_count, i))
        begin bad++; $display("FAIL rand_digit%0d got=%b want=%b", i, seen[i], expect_seg(m_count, i)); end
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [3:0] prev_an;
    bit found;
    drive(1'b1, 1'b0, 3'd0, 4321, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd4, 0, 1'b0);
    found = 1'b0;
    prev_an = an;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
      prev_an = an;
    end
    total++; if (!found) begin bad++; $display("FAIL midconv_wait got=timeout want=digit0 slot"); end
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    total++; if (an !== 4'b1111 || sseg !== 7'b1111111)
      begin bad++; $display("FAIL midconv_disp got=%b/%b want=1111/1111111", an, sseg); end
    total++; if (int'(dut.count) !== 0 || bus.synchInit !== 17'd0 || bus.tcLimitReached !== 1'b0)
      begin bad++; $display("FAIL midconv_state got=%0d/%0d/%b want=0/0/0", dut.count, bus.synchInit, bus.tcLimitReached); end
    step();
    reset = 1'b0;
    repeat (SETTLE) step();
    scan_display();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (!seen_mask[i] || seen[i] !== expect_seg(0, i))
        begin bad++; $display("FAIL midconv_digit%0d got=%b want=%b", i, seen[i], expect_seg(0, i)); end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want3;
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    want3 = 7'b1111111;
`else
    want3 = 7'b1000000;
`endif
    drive(1'b1, 1'b0, 3'd0, 567, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd4, 0, 1'b0);
    repeat (SETTLE) step();
    scan_display();
    total++; if (!seen_mask[3] || seen[3] !== want3)
      begin bad++; $display("FAIL lz_digit3 got=%b want=%b", seen[3], want3); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (!seen_mask[i] || seen[i] !== expect_seg(567, i))
        begin bad++; $display("FAIL lz_digit%0d got=%b want=%b", i, seen[i], expect_seg(567, i)); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_clamp();
    test_count_up();
    test_count_down();
    test_an_reset();
    test_random();
    test_reset_mid_conv();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
